// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
//   pwm_mode_e : counter alignment mode (edge or centre aligned)
//   cnt_dir_e  : period counter direction
//   pwm_fsm_t  : counter FSM state (mode + direction), kept as one struct so
//                checkers can bind to a single signal
//   clog2      : ceiling log2, used to size the debounce divider
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } cnt_dir_e;

    typedef struct packed {
        pwm_mode_e mode;
        cnt_dir_e  dir;
    } pwm_fsm_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Divider counter needs at least one bit even when DEB_DIV is 1.
    function automatic int deb_width(input int div);
        return (clog2(div) < 1) ? 1 : clog2(div);
    endfunction

endpackage

// File: rtl/pwm_gen_multi_btn_edge_sync.sv
// Enabled two-flop button sampler with rising-edge press pulse.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : sample enable (slow debounce tick)
//   d          : raw button level
//   pulse      : one-clk press pulse, only ever high while en is high
module btn_edge_sync
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic pulse
);

    logic q1_q, q1_d;
    logic q2_q, q2_d;

    always_comb begin
        q1_d  = en ? d    : q1_q;
        q2_d  = en ? q1_q : q2_q;
        // q2 catches up with q1 on the same tick, so the pulse lasts one clk.
        pulse = q1_q & ~q2_q & en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q1_q <= 1'b0;
            q2_q <= 1'b0;
        end else begin
            q1_q <= q1_d;
            q2_q <= q2_d;
        end
    end

endmodule

// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator with a shared period counter.
//   clk, rst_n   : clock, synchronous active-low reset
//   inc_btn      : raw increase buttons, bit c = channel c
//   dec_btn      : raw decrease buttons, bit c = channel c
//   center_mode  : 0 edge-aligned, 1 centre-aligned; taken at period boundary
//   pwm_out      : registered PWM outputs
//   duty_rd      : shadow duty of channel c at [c*CNT_W +: CNT_W]
//   period_start : one-clk pulse aligned with the first output cycle of a period
module pwm_gen_multi
    import pwm_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int PERIOD    = 10,
    parameter int CNT_W     = 8,
    parameter int STEP      = 1,
    parameter int INIT_DUTY = 5,
    parameter int DEB_DIV   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       inc_btn,
    input  logic [CHANNELS-1:0]       dec_btn,
    input  logic                      center_mode,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS*CNT_W-1:0] duty_rd,
    output logic                      period_start
);

    localparam int DEB_W = deb_width(DEB_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    // Slow enable for button sampling.
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             slow_en;

    always_comb begin
        slow_en   = (deb_cnt_q == DEB_W'(DEB_DIV - 1));
        deb_cnt_d = slow_en ? '0 : deb_cnt_q + DEB_W'(1);
    end

    // Shared period counter FSM.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pwm_fsm_t         fsm_q, fsm_d;
    logic             wrap;
    logic             period_start_q, period_start_d;

    always_comb begin
        cnt_d = cnt_q;
        fsm_d = fsm_q;
        wrap  = 1'b0;
        if (fsm_q.mode == PWM_EDGE) begin
            if (cnt_q == LAST) wrap = 1'b1;
            else               cnt_d = cnt_q + CNT_W'(1);
        end else if (fsm_q.dir == UP) begin
            // Top endpoint: turn around without moving, so it lasts 2 clk.
            if (cnt_q == LAST) fsm_d.dir = DOWN;
            else               cnt_d = cnt_q + CNT_W'(1);
        end else begin
            if (cnt_q == '0) wrap = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
        // Every period ends by re-entering 0/up; a new mode starts cleanly here.
        if (wrap) begin
            cnt_d      = '0;
            fsm_d.dir  = UP;
            fsm_d.mode = pwm_mode_e'(center_mode);
        end
        // 0/up occurs exactly once per period in both modes.
        period_start_d = (cnt_q == '0) && (fsm_q.dir == UP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_cnt_q      <= '0;
            cnt_q          <= '0;
            fsm_q          <= '{mode: PWM_EDGE, dir: UP};
            period_start_q <= 1'b0;
        end else begin
            deb_cnt_q      <= deb_cnt_d;
            cnt_q          <= cnt_d;
            fsm_q          <= fsm_d;
            period_start_q <= period_start_d;
        end
    end

    assign period_start = period_start_q;

    // Per-channel buttons, double-buffered duty and output flop.
    for (genvar c = 0; c < CHANNELS; c++) begin : gen_ch
        logic             inc_p, dec_p;
        logic [CNT_W-1:0] shadow_q, shadow_d;
        logic [CNT_W-1:0] active_q, active_d;
        logic [CNT_W:0]   up_w, dn_w;
        logic             pwm_q, pwm_d;

        btn_edge_sync u_inc (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (slow_en),
            .d     (inc_btn[c]),
            .pulse (inc_p)
        );

        btn_edge_sync u_dec (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (slow_en),
            .d     (dec_btn[c]),
            .pulse (dec_p)
        );

        always_comb begin
            // One extra bit so saturation never sees a wrapped value.
            up_w     = {1'b0, shadow_q} + (CNT_W+1)'(STEP);
            dn_w     = {1'b0, shadow_q} - (CNT_W+1)'(STEP);
            shadow_d = shadow_q;
            if (inc_p && !dec_p) begin
                shadow_d = (up_w > (CNT_W+1)'(PERIOD)) ? CNT_W'(PERIOD) : up_w[CNT_W-1:0];
            end else if (dec_p && !inc_p) begin
                shadow_d = dn_w[CNT_W] ? '0 : dn_w[CNT_W-1:0];
            end
            // Active duty only moves on the wrap so a period is never cut short.
            active_d = wrap ? shadow_q : active_q;
            pwm_d    = (cnt_q < active_q);
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                shadow_q <= CNT_W'(INIT_DUTY);
                active_q <= CNT_W'(INIT_DUTY);
                pwm_q    <= 1'b0;
            end else begin
                shadow_q <= shadow_d;
                active_q <= active_d;
                pwm_q    <= pwm_d;
            end
        end

        assign pwm_out[c]                  = pwm_q;
        assign duty_rd[c*CNT_W +: CNT_W]   = shadow_q;
    end

endmodule

// File: tb/tb_pwm_gen_multi.sv
module tb_pwm_gen_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  inc_btn;
    logic [1:0]  dec_btn;
    logic        center_mode;
    logic [1:0]  pwm_out;
    logic [15:0] duty_rd;
    logic        period_start;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_gen_multi #(
        .CHANNELS  (2),
        .PERIOD    (10),
        .CNT_W     (8),
        .STEP      (1),
        .INIT_DUTY (5),
        .DEB_DIV   (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc_btn      (inc_btn),
        .dec_btn      (dec_btn),
        .center_mode  (center_mode),
        .pwm_out      (pwm_out),
        .duty_rd      (duty_rd),
        .period_start (period_start)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic press(input logic [1:0] inc, input logic [1:0] dec);
        inc_btn = inc;
        dec_btn = dec;
        repeat (6) @(negedge clk);
        inc_btn = 2'b00;
        dec_btn = 2'b00;
        repeat (6) @(negedge clk);
    endtask

    // Returns at the next negedge where period_start is high.
    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Captures len cycles of both outputs from the next period start.
    task automatic measure(input int len, output logic [31:0] p0, output logic [31:0] p1,
                           output int ps_n, output logic ps_end, output bit ok);
        p0   = '0;
        p1   = '0;
        ps_n = 0;
        wait_ps(ok);
        for (int i = 0; i < len; i++) begin
            p0[i] = pwm_out[0];
            p1[i] = pwm_out[1];
            if (period_start === 1'b1) ps_n++;
            @(negedge clk);
        end
        ps_end = period_start;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] p0, p1;
        int          ps_n;
        logic        ps_end;
        bit          ok;
        inc_btn = 2'b00;
        dec_btn = 2'b00;
        center_mode = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pwm_out !== 2'b00) begin
            errors++; $display("FAIL reset_pwm: got %b expected 00", pwm_out);
        end
        checks++;
        if (duty_rd !== 16'h0505) begin
            errors++; $display("FAIL reset_duty: got %h expected 0505", duty_rd);
        end
        checks++;
        if (period_start !== 1'b0) begin
            errors++; $display("FAIL reset_ps: got %b expected 0", period_start);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (period_start !== 1'b1) begin
            errors++; $display("FAIL reset_first_ps: got %b expected 1", period_start);
        end
        measure(10, p0, p1, ps_n, ps_end, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL reset_timeout: got no period_start expected one");
        end
        checks++;
        if (p0[9:0] !== 10'h01F) begin
            errors++; $display("FAIL reset_ch0_wave: got %h expected 01f", p0[9:0]);
        end
        checks++;
        if (p1[9:0] !== 10'h01F) begin
            errors++; $display("FAIL reset_ch1_wave: got %h expected 01f", p1[9:0]);
        end
        checks++;
        if (ps_n !== 1 || ps_end !== 1'b1) begin
            errors++; $display("FAIL reset_period: got ps_n=%0d end=%b expected 1 1", ps_n, ps_end);
        end
    endtask

    task automatic test_inc_saturation();
        logic [7:0]  exp_tab [0:6];
        logic [31:0] p0, p1;
        int          ps_n;
        logic        ps_end;
        bit          ok;
        exp_tab = '{8'd7, 8'd8, 8'd9, 8'd10, 8'd10, 8'd10, 8'd10};
        inc_btn = 2'b01;
        repeat (20) @(negedge clk);
        checks++;
        if (duty_rd[7:0] !== 8'd6) begin
            errors++; $display("FAIL inc_hold: got %0d expected 6", duty_rd[7:0]);
        end
        inc_btn = 2'b00;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            press(2'b01, 2'b00);
            checks++;
            if (duty_rd[7:0] !== exp_tab[i]) begin
                errors++; $display("FAIL inc_step%0d: got %0d expected %0d", i, duty_rd[7:0], exp_tab[i]);
            end
        end
        measure(10, p0, p1, ps_n, ps_end, ok);
        checks++;
        if (!ok || p0[9:0] !== 10'h3FF) begin
            errors++; $display("FAIL inc_ch0_wave: got %h ok=%b expected 3ff", p0[9:0], ok);
        end
        checks++;
        if (p1[9:0] !== 10'h01F || duty_rd[15:8] !== 8'd5) begin
            errors++; $display("FAIL inc_ch1_untouched: got wave %h duty %0d expected 01f 5", p1[9:0], duty_rd[15:8]);
        end
    endtask

    task automatic test_dec_zero();
        logic [7:0]  exp_tab [0:5];
        logic [31:0] p0, p1;
        int          ps_n;
        logic        ps_end;
        bit          ok;
        exp_tab = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
        for (int i = 0; i < 6; i++) begin
            press(2'b00, 2'b10);
            checks++;
            if (duty_rd[15:8] !== exp_tab[i]) begin
                errors++; $display("FAIL dec_step%0d: got %0d expected %0d", i, duty_rd[15:8], exp_tab[i]);
            end
        end
        measure(10, p0, p1, ps_n, ps_end, ok);
        checks++;
        if (!ok || p1[9:0] !== 10'h000) begin
            errors++; $display("FAIL dec_ch1_wave: got %h ok=%b expected 000", p1[9:0], ok);
        end
        press(2'b11, 2'b11);
        checks++;
        if (duty_rd !== 16'h000A) begin
            errors++; $display("FAIL dec_simultaneous: got %h expected 000a", duty_rd);
        end
    endtask

    task automatic test_double_buffer();
        logic [9:0] pa, pb;
        bit         ok;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ps(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL dbuf_timeout: got no period_start expected one");
        end
        inc_btn = 2'b01;
        for (int i = 0; i < 10; i++) begin
            pa[i] = pwm_out[0];
            @(negedge clk);
        end
        checks++;
        if (period_start !== 1'b1 || duty_rd[7:0] !== 8'd6) begin
            errors++; $display("FAIL dbuf_mid_update: got ps=%b duty=%0d expected 1 6", period_start, duty_rd[7:0]);
        end
        inc_btn = 2'b00;
        for (int i = 0; i < 10; i++) begin
            pb[i] = pwm_out[0];
            @(negedge clk);
        end
        checks++;
        if (pa !== 10'h01F) begin
            errors++; $display("FAIL dbuf_current: got %h expected 01f", pa);
        end
        checks++;
        if (pb !== 10'h03F) begin
            errors++; $display("FAIL dbuf_next: got %h expected 03f", pb);
        end
    endtask

    task automatic test_center_mode();
        logic [31:0] p0, p1;
        int          ps_n;
        logic        ps_end;
        bit          ok;
        int          mid_ps;
        repeat (3) press(2'b00, 2'b01);
        checks++;
        if (duty_rd !== 16'h0503) begin
            errors++; $display("FAIL center_duty: got %h expected 0503", duty_rd);
        end
        wait_ps(ok);
        mid_ps = 0;
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            if (i == 4) center_mode = 1'b1;
            if (period_start === 1'b1) mid_ps++;
        end
        @(negedge clk);
        checks++;
        if (!ok || mid_ps !== 0 || period_start !== 1'b1) begin
            errors++; $display("FAIL center_edge_finish: got ok=%b mid=%0d ps=%b expected 1 0 1", ok, mid_ps, period_start);
        end
        measure(20, p0, p1, ps_n, ps_end, ok);
        checks++;
        if (!ok || p0[19:0] !== 20'hE0007) begin
            errors++; $display("FAIL center_ch0_wave: got %h ok=%b expected e0007", p0[19:0], ok);
        end
        checks++;
        if (p1[19:0] !== 20'hF801F) begin
            errors++; $display("FAIL center_ch1_wave: got %h expected f801f", p1[19:0]);
        end
        checks++;
        if (ps_n !== 1 || ps_end !== 1'b1) begin
            errors++; $display("FAIL center_period: got ps_n=%0d end=%b expected 1 1", ps_n, ps_end);
        end
    endtask

    task automatic test_reset_mid_center();
        logic [31:0] p0, p1;
        int          ps_n;
        logic        ps_end;
        bit          ok;
        wait_ps(ok);
        // Counter holds 7 on the way down during the 12th cycle of the period.
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        center_mode = 1'b0;
        @(negedge clk);
        checks++;
        if (!ok || pwm_out !== 2'b00 || period_start !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got ok=%b pwm=%b ps=%b expected 1 00 0", ok, pwm_out, period_start);
        end
        checks++;
        if (duty_rd !== 16'h0505) begin
            errors++; $display("FAIL midreset_duty: got %h expected 0505", duty_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (period_start !== 1'b1) begin
            errors++; $display("FAIL midreset_first_ps: got %b expected 1", period_start);
        end
        measure(10, p0, p1, ps_n, ps_end, ok);
        checks++;
        if (!ok || p0[9:0] !== 10'h01F || p1[9:0] !== 10'h01F) begin
            errors++; $display("FAIL midreset_wave: got %h %h ok=%b expected 01f 01f", p0[9:0], p1[9:0], ok);
        end
        checks++;
        if (ps_n !== 1 || ps_end !== 1'b1) begin
            errors++; $display("FAIL midreset_period: got ps_n=%0d end=%b expected 1 1", ps_n, ps_end);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        inc_btn = 2'b00;
        dec_btn = 2'b00;
        center_mode = 1'b0;
        test_reset();
        test_inc_saturation();
        test_dec_zero();
        test_double_buffer();
        test_center_mode();
        test_reset_mid_center();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
